// File: rtl/master_tx_if.sv
// Bus bundle for master_tx: FIFO push side plus the valid/ready offer channel.
interface master_tx_if #(
    parameter int unsigned NUM = 8
);
    logic            push;
    logic [NUM-1:0]  push_data;
    logic            full;
    logic            overflow;
    logic            valid;
    logic [NUM-1:0]  data_out_m;
    logic            ready;
    logic            busy;
    logic            timeout;
    logic [15:0]     sent_cnt;

    modport master (
        input  push,
        input  push_data,
        input  ready,
        input  busy,
        output full,
        output overflow,
        output valid,
        output data_out_m,
        output timeout,
        output sent_cnt
    );

    modport slave (
        output push,
        output push_data,
        output ready,
        output busy,
        input  full,
        input  overflow,
        input  valid,
        input  data_out_m,
        input  timeout,
        input  sent_cnt
    );
endinterface

// File: rtl/master_tx.sv
// Buffered transmitter: small FIFO feeding a valid/ready offer with a
// stall input, a per-word wait timeout and a completed-transfer counter.
module master_tx #(
    parameter int unsigned NUM     = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic         clk,
    input logic         rst,
    master_tx_if.master bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e          state_q, state_d;
    logic [NUM-1:0]  mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [NUM-1:0]  data_q;
    logic [WW-1:0]   wait_q, wait_d;
    logic [15:0]     sent_q;
    logic            overflow_q;
    logic            timeout_q;

    logic            full;
    logic            empty;
    logic            push_ok;
    logic            pop;
    logic            complete;
    logic            drop;

    // Occupancy is registered, so a same-cycle pop never frees a slot for a push.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = bus.push && !full;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        pop      = 1'b0;
        complete = 1'b0;
        drop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !bus.busy) begin
                    pop     = 1'b1;
                    wait_d  = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (bus.ready) begin
                    complete = 1'b1;
                    wait_d   = '0;
                    if (!empty && !bus.busy) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    // This edge would bring the counter to TIMEOUT: drop the word.
                    drop    = 1'b1;
                    wait_d  = '0;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            wait_q     <= '0;
            sent_q     <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            timeout_q <= drop;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                data_q   <= mem[rd_ptr_q];
            end
            if (complete) begin
                sent_q <= sent_q + 16'd1;
            end
            if (bus.push && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; it is only read behind a non-zero occupancy.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.push_data;
        end
    end

    assign bus.full       = full;
    assign bus.overflow   = overflow_q;
    assign bus.valid      = (state_q == StSend);
    assign bus.data_out_m = data_q;
    assign bus.timeout    = timeout_q;
    assign bus.sent_cnt   = sent_q;

endmodule

// File: tb/tb_master_tx.sv
// Directed bench for master_tx: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every completed or dropped offer.
module tb_master_tx;

    localparam int unsigned NUM     = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;
    logic [NUM-1:0] exp_q [$];

    always #5 clk = ~clk;

    master_tx_if #(.NUM(NUM)) bus ();

    master_tx #(
        .NUM     (NUM),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [NUM-1:0] d);
        bus.push      = 1'b1;
        bus.push_data = d;
        exp_q.push_back(d);
        step(1);
        bus.push = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.push = 1'b0;
        exp_q.delete();
        step(2);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: a word offered with ready high completes on the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected: got 0x%0h want no word", bus.data_out_m);
                end else begin
                    check("mon_data", 32'(bus.data_out_m), 32'(exp_q.pop_front()));
                end
            end
            if (bus.timeout) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_drop_unexpected: got 0x%0h want no word", bus.data_out_m);
                end else begin
                    check("mon_dropped", 32'(bus.data_out_m), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] vhist;
        logic       vseen;
        logic       stable;
        int         n;

        rst           = 1'b1;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.ready     = 1'b0;
        bus.busy      = 1'b0;
        step(2);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_data", 32'(bus.data_out_m), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        check("rst_sent", 32'(bus.sent_cnt), 0);

        // Single word into an idle block: two-edge latency.
        bus.ready = 1'b1;
        do_reset();
        push_word(8'h5A);
        check("lat_edge1_valid", 32'(bus.valid), 0);
        step(1);
        check("lat_edge2_valid", 32'(bus.valid), 1);
        check("lat_edge2_data", 32'(bus.data_out_m), 32'h5A);
        step(1);
        check("single_done_valid", 32'(bus.valid), 0);
        check("single_sent", 32'(bus.sent_cnt), 1);

        // Back-to-back stream with ready held high.
        do_reset();
        vhist = '0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) push_word(8'(c + 1));
            else step(1);
            vhist[c] = bus.valid;
        end
        check("b2b_valid_pattern", 32'(vhist), 32'h1E);
        check("b2b_sent", 32'(bus.sent_cnt), 4);

        // Fill while stalled, overflow push, then release busy and drain.
        bus.ready = 1'b0;
        bus.busy  = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'(8'hA1 + i));
        check("fill_full", 32'(bus.full), 1);
        check("fill_no_overflow", 32'(bus.overflow), 0);
        bus.push      = 1'b1;
        bus.push_data = 8'hA5;
        step(1);
        bus.push = 1'b0;
        check("ovf_overflow", 32'(bus.overflow), 1);
        check("ovf_full", 32'(bus.full), 1);
        check("busy_holds_valid", 32'(bus.valid), 0);
        bus.busy = 1'b0;
        step(1);
        check("busy_release_valid", 32'(bus.valid), 1);
        check("busy_release_data", 32'(bus.data_out_m), 32'hA1);
        bus.ready = 1'b1;
        step(5);
        check("drain_sent", 32'(bus.sent_cnt), 4);
        check("drain_empty_q", exp_q.size(), 0);
        check("drain_overflow_sticky", 32'(bus.overflow), 1);
        check("drain_not_full", 32'(bus.full), 0);

        // Ready arrives on the very edge the wait counter would hit TIMEOUT.
        bus.ready = 1'b0;
        do_reset();
        push_word(8'hD1);
        step(1);
        check("edge_valid", 32'(bus.valid), 1);
        step(TIMEOUT - 1);
        check("edge_still_valid", 32'(bus.valid), 1);
        bus.ready = 1'b1;
        step(1);
        check("edge_no_timeout", 32'(bus.timeout), 0);
        check("edge_sent", 32'(bus.sent_cnt), 1);
        check("edge_valid_low", 32'(bus.valid), 0);

        // Full timeout: word dropped, next queued word offered afterwards.
        bus.ready = 1'b0;
        push_word(8'hC1);
        push_word(8'hC2);
        check("to_valid", 32'(bus.valid), 1);
        check("to_data", 32'(bus.data_out_m), 32'hC1);
        n      = 0;
        stable = 1'b1;
        while (!bus.timeout && n < 400) begin
            step(1);
            n++;
            if (!bus.timeout && (!bus.valid || bus.data_out_m !== 8'hC1)) stable = 1'b0;
        end
        check("to_cycles", n, TIMEOUT);
        check("to_offer_stable", 32'(stable), 1);
        check("to_valid_low", 32'(bus.valid), 0);
        check("to_sent_unchanged", 32'(bus.sent_cnt), 1);
        step(1);
        check("to_pulse_width", 32'(bus.timeout), 0);
        check("to_next_valid", 32'(bus.valid), 1);
        check("to_next_data", 32'(bus.data_out_m), 32'hC2);
        bus.ready = 1'b1;
        step(1);
        check("to_next_sent", 32'(bus.sent_cnt), 2);

        // Reset mid-transfer with three words queued.
        bus.ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'(8'hE1 + i));
        check("mid_valid", 32'(bus.valid), 1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(bus.valid), 0);
        check("mid_rst_data", 32'(bus.data_out_m), 0);
        check("mid_rst_full", 32'(bus.full), 0);
        check("mid_rst_sent", 32'(bus.sent_cnt), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.ready = 1'b1;
        vseen     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            vseen |= bus.valid;
        end
        check("post_rst_no_valid", 32'(vseen), 0);
        push_word(8'hF1);
        step(1);
        check("post_rst_data", 32'(bus.data_out_m), 32'hF1);
        step(1);
        check("post_rst_sent", 32'(bus.sent_cnt), 1);
        check("end_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/master_tx.md
MASTER_TX -- requirements
Module: master_tx

Interface
REQ-001 Parameter NUM, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 4: input FIFO depth in words, power of two, minimum 2.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles valid may stay high without ready, minimum 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 push  input  1  request to write push_data into the FIFO.
REQ-007 push_data  input  NUM  word to enqueue.
REQ-008 full  output  1  FIFO holds DEPTH words.
REQ-009 overflow  output  1  sticky: a push arrived while full was high.
REQ-010 valid  output  1  data_out_m holds a word offered to the receiver.
REQ-011 data_out_m  output  NUM  word offered to the receiver.
REQ-012 ready  input  1  receiver accepts the offered word.
REQ-013 busy  input  1  receiver stall; no new word is launched while high.
REQ-014 timeout  output  1  one-cycle pulse when an offered word is dropped.
REQ-015 sent_cnt  output  16  count of completed transfers, wraps 65535->0.

Function
REQ-016 A push is accepted on a rising edge only if push=1 and full=0 before that edge.
REQ-017 A push with full=1 is discarded and sets overflow, which stays 1 until reset.
REQ-018 full and FIFO occupancy are registered; a pop in the same cycle does not make room for a push while full=1.
REQ-019 The FIFO is first-in, first-out; read and write pointers wrap modulo DEPTH.
REQ-020 The FSM has two states: IDLE (valid=0) and SEND (valid=1).
REQ-021 IDLE->SEND occurs when the FIFO is non-empty and busy=0: the head word is popped into data_out_m and valid=1 after the same edge.
REQ-022 Push-to-valid latency into an empty, idle block is 2 edges: the word is written on edge N and valid is high after edge N+1.
REQ-023 A transfer completes on an edge where valid=1 and ready=1; sent_cnt increments on that edge.
REQ-024 In SEND, valid and data_out_m stay stable until the transfer completes or a timeout occurs.
REQ-025 busy does not retract a word already offered; it only blocks the next launch.
REQ-026 On completion, if the FIFO is non-empty and busy=0, the next word loads on the same edge and the state stays SEND, giving one word per cycle back-to-back.
REQ-027 On completion otherwise, the state goes to IDLE and valid=0.
REQ-028 A wait counter clears on entry to SEND and on every completion, and increments on each SEND cycle with ready=0.
REQ-029 When the wait counter reaches TIMEOUT: the word is dropped, timeout=1 for exactly one cycle, valid=0, the state goes to IDLE, and sent_cnt does not increment.
REQ-030 If ready=1 on the edge where the wait counter would reach TIMEOUT, the transfer completes and no timeout is raised.
REQ-031 data_out_m keeps its last value while in IDLE.

Reset
REQ-032 While rst=1, regardless of clk: valid=0, data_out_m=0, full=0, overflow=0, timeout=0, sent_cnt=0, FIFO empty, wait counter=0, state=IDLE.
REQ-033 Reset asserted mid-transfer drops the offered word and all FIFO contents, and no completion is counted.
REQ-034 The first launch after reset release is no earlier than the second rising edge after release.

Verification
REQ-035 The bench shall cover: push 0x5A into an idle block with ready=1 and busy=0 -> valid high after 2 edges with data_out_m=0x5A, one transfer, sent_cnt=1.
REQ-036 The bench shall cover: push 0x01..0x04 on consecutive cycles with ready held 1 -> four consecutive valid cycles carrying 0x01, 0x02, 0x03, 0x04, and sent_cnt=4.
REQ-037 The bench shall cover: fill the FIFO with 4 words while ready=0, then push a fifth -> full=1, overflow=1, fifth word never appears on data_out_m.
REQ-038 The bench shall cover: busy=1 while the FIFO holds words and valid=0 -> valid stays 0; release busy -> valid rises on the next edge.
REQ-039 The bench shall cover: ready=0 for TIMEOUT=255 cycles after valid rises -> timeout pulses for 1 cycle, valid=0, sent_cnt unchanged, next queued word is offered afterwards.
REQ-040 The bench shall cover: assert rst while valid=1 with 3 words queued -> all outputs at reset values immediately, and no valid after release until a new push.
